// File: rtl/br_predictor_gen2.sv
// Two-bit saturating-counter branch direction predictor, bimodal or gshare indexed,
// with a speculative global history that is repaired from the ROB snapshot on a mispredict.
module br_predictor_gen2 #(
    parameter int         PHT_BITS  = 8,
    parameter int         HIST_BITS = 8,
    parameter int         MODE      = 0,
    parameter logic [1:0] CNT_INIT  = 2'b01
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic [31:0]          qry_pc,
    input  logic                 qry_fire,
    output logic                 pred_taken,
    output logic [PHT_BITS-1:0]  pred_idx,
    output logic [HIST_BITS-1:0] pred_ghr,
    input  logic                 upd_valid,
    input  logic [PHT_BITS-1:0]  upd_idx,
    input  logic [HIST_BITS-1:0] upd_ghr,
    input  logic                 upd_taken,
    input  logic                 upd_mispred,
    output logic [31:0]          stat_commits,
    output logic [31:0]          stat_mispreds
);

    localparam int   ENTRIES = 1 << PHT_BITS;
    localparam logic USE_GHR = (MODE == 1);

    logic [1:0]           pht_reg [ENTRIES];
    logic [1:0]           cnt_cur;
    logic [1:0]           cnt_next;
    logic [HIST_BITS-1:0] ghr_reg;
    logic [HIST_BITS-1:0] ghr_next;
    logic [HIST_BITS-1:0] ghr_fire;
    logic [HIST_BITS-1:0] ghr_fix;
    logic [31:0]          commits_reg;
    logic [31:0]          mispreds_reg;
    logic [PHT_BITS-1:0]  pc_idx;
    logic [PHT_BITS-1:0]  ghr_ext;
    logic                 upd_en;
    logic                 fix_en;
    logic                 unused_bits;

    assign upd_en = rdy_in & upd_valid;
    assign fix_en = upd_en & upd_mispred;

    assign unused_bits = ^{qry_pc[31:PHT_BITS+2], qry_pc[1:0], upd_ghr[HIST_BITS-1]};

    // Indexing: history is zero-extended and only folded in for gshare.
    assign pc_idx = qry_pc[PHT_BITS+1:2];

    always_comb begin
        ghr_ext                  = '0;
        ghr_ext[HIST_BITS-1:0]   = ghr_reg;
    end

    assign pred_idx   = pc_idx ^ (ghr_ext & {PHT_BITS{USE_GHR}});
    assign pred_taken = pht_reg[pred_idx][1];
    assign pred_ghr   = ghr_reg;

    generate
        if (HIST_BITS == 1) begin : g_hist1
            assign ghr_fire = pred_taken;
            assign ghr_fix  = upd_taken;
        end else begin : g_histn
            assign ghr_fire = {ghr_reg[HIST_BITS-2:0], pred_taken};
            assign ghr_fix  = {upd_ghr[HIST_BITS-2:0], upd_taken};
        end
    endgenerate

    // A mispredict repair takes priority over a speculative shift in the same cycle.
    always_comb begin
        ghr_next = ghr_reg;
        if (fix_en) begin
            ghr_next = ghr_fix;
        end else if (rdy_in && qry_fire) begin
            ghr_next = ghr_fire;
        end
    end

    assign cnt_cur = pht_reg[upd_idx];

    always_comb begin
        cnt_next = cnt_cur;
        if (upd_taken && cnt_cur != 2'b11) begin
            cnt_next = cnt_cur + 2'd1;
        end else if (!upd_taken && cnt_cur != 2'b00) begin
            cnt_next = cnt_cur - 2'd1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < ENTRIES; i++) begin
                pht_reg[i] <= CNT_INIT;
            end
        end else if (upd_en) begin
            pht_reg[upd_idx] <= cnt_next;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ghr_reg      <= '0;
            commits_reg  <= '0;
            mispreds_reg <= '0;
        end else begin
            ghr_reg <= ghr_next;
            if (upd_en) begin
                commits_reg <= commits_reg + 32'd1;
            end
            if (fix_en) begin
                mispreds_reg <= mispreds_reg + 32'd1;
            end
        end
    end

    assign stat_commits  = commits_reg;
    assign stat_mispreds = mispreds_reg;

endmodule

// File: tb/tb_br_predictor_gen2.sv
// Directed bench: a bimodal and a gshare instance driven by the same stimulus,
// each checked against hand-computed counter, history and statistic values.
module tb_br_predictor_gen2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic [31:0] qry_pc = '0;
    logic        qry_fire = 1'b0;
    logic        upd_valid = 1'b0;
    logic [7:0]  upd_idx = '0;
    logic [7:0]  upd_ghr = '0;
    logic        upd_taken = 1'b0;
    logic        upd_mispred = 1'b0;

    logic        p0_taken, p1_taken;
    logic [7:0]  p0_idx, p1_idx, p0_ghr, p1_ghr;
    logic [31:0] c0, c1, m0, m1;

    int total = 0;
    int bad   = 0;

    br_predictor_gen2 #(.PHT_BITS(8), .HIST_BITS(8), .MODE(0), .CNT_INIT(2'b01)) dut0 (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
        .qry_pc(qry_pc), .qry_fire(qry_fire),
        .pred_taken(p0_taken), .pred_idx(p0_idx), .pred_ghr(p0_ghr),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_ghr(upd_ghr),
        .upd_taken(upd_taken), .upd_mispred(upd_mispred),
        .stat_commits(c0), .stat_mispreds(m0)
    );

    br_predictor_gen2 #(.PHT_BITS(8), .HIST_BITS(8), .MODE(1), .CNT_INIT(2'b01)) dut1 (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
        .qry_pc(qry_pc), .qry_fire(qry_fire),
        .pred_taken(p1_taken), .pred_idx(p1_idx), .pred_ghr(p1_ghr),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_ghr(upd_ghr),
        .upd_taken(upd_taken), .upd_mispred(upd_mispred),
        .stat_commits(c1), .stat_mispreds(m1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s got=%h", tag, got);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One committed branch, held for exactly one rising edge.
    task automatic upd(input logic [7:0] idx, input logic t, input logic m, input logic [7:0] g);
        upd_idx     = idx;
        upd_taken   = t;
        upd_mispred = m;
        upd_ghr     = g;
        upd_valid   = 1'b1;
        tick();
        upd_valid   = 1'b0;
        upd_mispred = 1'b0;
    endtask

    logic [31:0] pcs [4] = '{32'h0000_0000, 32'h0000_0104, 32'h0000_03FC, 32'h0000_ABCD};

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_commits", c1, 32'd0);
        check("rst_mispreds", m1, 32'd0);
        check("rst_ghr", {24'd0, p1_ghr}, 32'd0);
        rst = 1'b0;

        qry_pc = 32'h100;
        #1;
        check("bim_idx_100", {24'd0, p0_idx}, 32'h40);
        check("bim_taken_100", {31'd0, p0_taken}, 32'd0);
        check("bim_ghr_100", {24'd0, p0_ghr}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            qry_pc = pcs[i];
            #1;
            check($sformatf("init_nt0_%0d", i), {31'd0, p0_taken}, 32'd0);
            check($sformatf("init_nt1_%0d", i), {31'd0, p1_taken}, 32'd0);
        end

        // Bimodal counter walk at index 0x40, starting from 01.
        qry_pc = 32'h100;
        repeat (2) upd(8'h40, 1'b1, 1'b0, 8'h00);
        check("bim_2t", {31'd0, p0_taken}, 32'd1);
        repeat (2) upd(8'h40, 1'b1, 1'b0, 8'h00);
        check("bim_sat3a", {31'd0, p0_taken}, 32'd1);
        upd(8'h40, 1'b0, 1'b0, 8'h00);
        check("bim_sat3b", {31'd0, p0_taken}, 32'd1);
        upd(8'h40, 1'b0, 1'b0, 8'h00);
        check("bim_dec", {31'd0, p0_taken}, 32'd0);
        repeat (2) upd(8'h40, 1'b0, 1'b0, 8'h00);
        upd(8'h40, 1'b1, 1'b0, 8'h00);
        check("bim_sat0a", {31'd0, p0_taken}, 32'd0);
        upd(8'h40, 1'b1, 1'b0, 8'h00);
        check("bim_sat0b", {31'd0, p0_taken}, 32'd1);
        check("bim_commits", c0, 32'd10);
        check("bim_mispreds", m0, 32'd0);

        // Gshare history and indexing.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        qry_pc   = 32'h100;
        qry_fire = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("gs_nt_%0d", i), {31'd0, p1_taken}, 32'd0);
            tick();
        end
        qry_fire = 1'b0;
        check("gs_ghr0", {24'd0, p1_ghr}, 32'h00);
        repeat (2) upd(8'h40, 1'b1, 1'b0, 8'h00);
        qry_fire = 1'b1;
        #1;
        check("gs_hit", {31'd0, p1_taken}, 32'd1);
        check("gs_idx40", {24'd0, p1_idx}, 32'h40);
        tick();
        qry_fire = 1'b0;
        check("gs_ghr1", {24'd0, p1_ghr}, 32'h01);
        check("gs_idx41", {24'd0, p1_idx}, 32'h41);
        check("bim_ghr1", {24'd0, p0_ghr}, 32'h01);
        check("bim_idx_fixed", {24'd0, p0_idx}, 32'h40);

        // Mispredict repair against a same-cycle taken shift.
        qry_pc      = 32'h104;
        qry_fire    = 1'b1;
        upd_valid   = 1'b1;
        upd_idx     = 8'h10;
        upd_mispred = 1'b1;
        upd_ghr     = 8'h5A;
        upd_taken   = 1'b0;
        #1;
        check("mp_pred", {31'd0, p1_taken}, 32'd1);
        check("mp_snap", {24'd0, p1_ghr}, 32'h01);
        tick();
        qry_fire    = 1'b0;
        upd_valid   = 1'b0;
        upd_mispred = 1'b0;
        check("mp_wins", {24'd0, p1_ghr}, 32'hB4);
        check("mp_commits", c1, 32'd3);
        check("mp_mispreds", m1, 32'd1);

        // Mispredict flag without a commit is ignored.
        qry_pc      = 32'h100;
        qry_fire    = 1'b1;
        upd_mispred = 1'b1;
        upd_ghr     = 8'hFF;
        upd_taken   = 1'b1;
        #1;
        check("nv_idx", {24'd0, p1_idx}, 32'hF4);
        check("nv_pred", {31'd0, p1_taken}, 32'd0);
        tick();
        qry_fire    = 1'b0;
        upd_mispred = 1'b0;
        check("nv_ghr", {24'd0, p1_ghr}, 32'h68);
        check("nv_commits", c1, 32'd3);
        check("nv_mispreds", m1, 32'd1);

        // Stall: nothing moves while rdy is low.
        qry_pc = 32'hA0;
        #1;
        check("st_idx", {24'd0, p1_idx}, 32'h40);
        check("st_pred", {31'd0, p1_taken}, 32'd1);
        rdy         = 1'b0;
        qry_fire    = 1'b1;
        upd_valid   = 1'b1;
        upd_mispred = 1'b1;
        upd_idx     = 8'h40;
        upd_taken   = 1'b0;
        upd_ghr     = 8'h00;
        repeat (2) tick();
        check("st_ghr", {24'd0, p1_ghr}, 32'h68);
        check("st_commits", c1, 32'd3);
        check("st_mispreds", m1, 32'd1);
        check("st_pht", {31'd0, p1_taken}, 32'd1);
        qry_pc = 32'h1A0;
        #1;
        check("st_track", {24'd0, p1_idx}, 32'h00);
        qry_pc      = 32'hA0;
        rdy         = 1'b1;
        qry_fire    = 1'b0;
        upd_mispred = 1'b0;
        tick();
        upd_valid = 1'b0;
        check("rs_commits", c1, 32'd4);
        check("rs_pred2", {31'd0, p1_taken}, 32'd1);
        upd(8'h40, 1'b0, 1'b0, 8'h00);
        check("rs_pred1", {31'd0, p1_taken}, 32'd0);
        check("rs_commits2", c1, 32'd5);

        // Asynchronous reset mid-cycle with an update pending.
        upd_valid = 1'b1;
        upd_idx   = 8'h40;
        upd_taken = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("ar_commits", c1, 32'd0);
        check("ar_ghr", {24'd0, p1_ghr}, 32'h00);
        qry_pc = 32'h100;
        #1;
        check("ar_pht", {31'd0, p1_taken}, 32'd0);
        tick();
        check("ar_hold", c1, 32'd0);
        rst = 1'b0;
        #1;
        check("ar_release", c1, 32'd0);
        tick();
        upd_valid = 1'b0;
        check("ar_first", c1, 32'd1);
        check("ar_first_pht", {31'd0, p1_taken}, 32'd1);

        // Statistic wrap from an all-ones preload.
        force dut1.commits_reg = 32'hFFFF_FFFF;
        #1;
        release dut1.commits_reg;
        #1;
        check("wr_preload", c1, 32'hFFFF_FFFF);
        upd(8'h20, 1'b1, 1'b1, 8'h00);
        check("wr_commits", c1, 32'd0);
        check("wr_mispreds", m1, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/br_predictor_gen2.md
BR_PREDICTOR_GEN2 -- requirements
Module: br_predictor_gen2

Interface
REQ-001 Parameter PHT_BITS, default 8, log2 of pattern-history-table entries (legal range 2..12).
REQ-002 Parameter HIST_BITS, default 8, global-history width (legal range 1..PHT_BITS).
REQ-003 Parameter MODE, default 0, index mode: 0 = bimodal, 1 = gshare.
REQ-004 Parameter CNT_INIT, default 2'b01, reset value of every 2-bit counter.
REQ-005 clk_in  input  1  system clock; all state changes on its rising edge.
REQ-006 rst_in  input  1  reset, asynchronous, active-high.
REQ-007 rdy_in  input  1  ready; when low, no state changes.
REQ-008 qry_pc  input  32  address of the branch being decoded.
REQ-009 qry_fire  input  1  branch is issued this cycle (decoder not stalled, opcode is BR).
REQ-010 pred_taken  output  1  combinational prediction for qry_pc.
REQ-011 pred_idx  output  PHT_BITS  combinational table index used for qry_pc, carried in the ROB.
REQ-012 pred_ghr  output  HIST_BITS  current speculative history, snapshot carried in the ROB.
REQ-013 upd_valid  input  1  ROB commits a branch this cycle.
REQ-014 upd_idx  input  PHT_BITS  pred_idx recorded at issue.
REQ-015 upd_ghr  input  HIST_BITS  pred_ghr recorded at issue.
REQ-016 upd_taken  input  1  resolved direction.
REQ-017 upd_mispred  input  1  resolved direction differs from prediction.
REQ-018 stat_commits  output  32  committed-branch count.
REQ-019 stat_mispreds  output  32  mispredicted-branch count.

Function
REQ-020 PHT SHALL hold 2^PHT_BITS 2-bit saturating counters; speculative history register ghr SHALL be HIST_BITS wide.
REQ-021 MODE 0: pred_idx SHALL equal qry_pc[PHT_BITS+1:2].
REQ-022 MODE 1: pred_idx SHALL equal qry_pc[PHT_BITS+1:2] XOR ghr zero-extended to PHT_BITS.
REQ-023 pred_taken SHALL equal bit 1 of PHT[pred_idx], read combinationally, zero cycles of latency.
REQ-024 pred_ghr SHALL equal ghr, the value before any shift caused by the current cycle's qry_fire.
REQ-025 On qry_fire with upd_mispred not asserted, ghr SHALL become {ghr[HIST_BITS-2:0], pred_taken}; when HIST_BITS=1, ghr SHALL become pred_taken.
REQ-026 On upd_valid, PHT[upd_idx] SHALL increment when upd_taken is high and decrement when upd_taken is low, saturating at 3 and 0 with no wrap.
REQ-027 On upd_valid with upd_mispred high, ghr SHALL become {upd_ghr[HIST_BITS-2:0], upd_taken}, and this SHALL override any qry_fire shift in the same cycle.
REQ-028 Same-cycle query and update to the same index: the query SHALL see the pre-update counter; the update SHALL land at the clock edge.
REQ-029 upd_mispred without upd_valid SHALL be ignored.
REQ-030 stat_commits SHALL increment by 1 on each upd_valid; stat_mispreds SHALL increment by 1 on each upd_valid with upd_mispred; both SHALL wrap modulo 2^32.
REQ-031 With rdy_in low, PHT, ghr and the statistics SHALL hold; combinational outputs SHALL still track the inputs.
REQ-032 MODE 0: ghr SHALL still be maintained per REQ-025/REQ-027; it only has no effect on indexing.

Reset
REQ-033 While rst_in is high, every PHT entry SHALL be CNT_INIT, ghr SHALL be 0, and stat_commits and stat_mispreds SHALL be 0.
REQ-034 Reset asserted mid-operation SHALL discard any update pending in that cycle; the first update honoured SHALL be on the first rising edge after rst_in falls with rdy_in high.
REQ-035 After reset with CNT_INIT=01, pred_taken SHALL be 0 for every qry_pc.

Verification
REQ-036 Reset, MODE 0, qry_pc=0x100 -> pred_idx=0x40, pred_taken=0, pred_ghr=0.
REQ-037 MODE 0, two upd_valid cycles with upd_idx=0x40, upd_taken=1 -> pred_taken=1 for 0x100; two further taken updates -> counter stays at 3; one not-taken update -> pred_taken still 1.
REQ-038 MODE 1, HIST_BITS=8, qry_fire three cycles with pred_taken=0,0,0 -> ghr=0x00; then counter for idx 0x40 forced to 3 and qry_fire with qry_pc=0x100 -> ghr=0x01; next query at qry_pc=0x100 -> pred_idx=0x41.
REQ-039 Same cycle: qry_fire with pred_taken=1 and upd_valid, upd_mispred=1, upd_ghr=0x5A, upd_taken=0 -> next ghr=0xB4 (mispredict wins).
REQ-040 rdy_in low with upd_valid=1 and qry_fire=1 -> PHT, ghr and statistics unchanged; rdy_in high again -> resumes normal operation.
REQ-041 Preload stat_commits=0xFFFFFFFF via 2^32-1 updates (or force), then one upd_valid with upd_mispred=1 -> stat_commits=0, stat_mispreds incremented by 1.
